kernel3_gmem_c_m_axi_write_arbiter: RTL and testbench

Two-port write-channel arbiter placed in front of the gmem_C write throttle. It shares one AXI-style AW/W request path (the throttle's TOP side) between two kernel-side requesters. AW is arbitrated round-robin, and each granted burst's port ID is queued in order. W beats are then steered from the owning port until that burst's WLAST completes, so bursts are never interleaved on W.

---
 rtl/kernel3_gmem_c_m_axi_write_arbiter.sv | 114 +++++++++++
 tb/tb_kernel3_gmem_c_m_axi_write_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel3_gmem_c_m_axi_write_arbiter.sv
// Two-port AW/W write arbiter: round-robin AW (combinational, lock-held while stalled), W steered in AW order.
// AW ready withheld while the order queue is full; W beats follow the queue head one burst at a time.
module kernel3_gmem_c_m_axi_write_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAXREQS    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic [ADDR_WIDTH-1:0]   in_P0_AWADDR,
  input  logic [7:0]              in_P0_AWLEN,
  input  logic                    in_P0_AWVALID,
  output logic                    out_P0_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   in_P1_AWADDR,
  input  logic [7:0]              in_P1_AWLEN,
  input  logic                    in_P1_AWVALID,
  output logic                    out_P1_AWREADY,
  input  logic [DATA_WIDTH-1:0]   in_P0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] in_P0_WSTRB,
  input  logic                    in_P0_WLAST,
  input  logic                    in_P0_WVALID,
  output logic                    out_P0_WREADY,
  input  logic [DATA_WIDTH-1:0]   in_P1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] in_P1_WSTRB,
  input  logic                    in_P1_WLAST,
  input  logic                    in_P1_WVALID,
  output logic                    out_P1_WREADY,
  output logic [ADDR_WIDTH-1:0]   out_AWADDR,
  output logic [7:0]              out_AWLEN,
  output logic                    out_AWVALID,
  input  logic                    in_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_WSTRB,
  output logic                    out_WLAST,
  output logic                    out_WVALID,
  input  logic                    in_WREADY
);

  localparam int PW = $clog2(MAXREQS);
  localparam int CW = PW + 1;

  logic               lock, owner, prio, grant;
  logic [MAXREQS-1:0] q_mem;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               q_not_full, q_valid, head;
  logic               gnt_awvalid, aw_hs, w_route, w_pop;

  // A stalled request keeps its grant so the presented address stays stable.
  always_comb begin
    grant = 1'b0;
    if (lock)
      grant = owner;
    else if (in_P0_AWVALID && in_P1_AWVALID)
      grant = prio;
    else if (in_P1_AWVALID)
      grant = 1'b1;
  end

  assign q_not_full  = count < CW'(MAXREQS);
  assign q_valid     = count != '0;
  assign head        = q_mem[rd_ptr];

  assign gnt_awvalid    = grant ? in_P1_AWVALID : in_P0_AWVALID;
  assign out_AWVALID    = gnt_awvalid & q_not_full & ~reset;
  assign out_AWADDR     = grant ? in_P1_AWADDR : in_P0_AWADDR;
  assign out_AWLEN      = grant ? in_P1_AWLEN  : in_P0_AWLEN;
  assign out_P0_AWREADY = ~grant & in_P0_AWVALID & in_AWREADY & q_not_full & ~reset;
  assign out_P1_AWREADY =  grant & in_P1_AWVALID & in_AWREADY & q_not_full & ~reset;
  assign aw_hs          = out_AWVALID & in_AWREADY;

  // W follows the oldest granted burst; nothing routes while the queue is empty.
  assign w_route       = q_valid & ~reset;
  assign out_WVALID    = w_route & (head ? in_P1_WVALID : in_P0_WVALID);
  assign out_WDATA     = head ? in_P1_WDATA : in_P0_WDATA;
  assign out_WSTRB     = head ? in_P1_WSTRB : in_P0_WSTRB;
  assign out_WLAST     = head ? in_P1_WLAST : in_P0_WLAST;
  assign out_P0_WREADY = w_route & ~head & in_WREADY;
  assign out_P1_WREADY = w_route &  head & in_WREADY;
  assign w_pop         = out_WVALID & in_WREADY & out_WLAST;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock   <= 1'b0;
      owner  <= 1'b0;
      prio   <= 1'b0;
      q_mem  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (aw_hs) begin
        lock <= 1'b0;
        prio <= ~grant;
      end else if (out_AWVALID) begin
        lock  <= 1'b1;
        owner <= grant;
      end
      if (aw_hs) begin
        q_mem[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (w_pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({aw_hs, w_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_write_arbiter.sv
// Directed bench for the two-port write arbiter (MAXREQS=4): reset, round-robin, stall lock, burst order, full queue, reset mid-burst.
module tb_kernel3_gmem_c_m_axi_write_arbiter;

  logic        clk = 1'b0;
  logic        reset, clk_en;
  logic [31:0] in_P0_AWADDR, in_P1_AWADDR, out_AWADDR;
  logic [7:0]  in_P0_AWLEN, in_P1_AWLEN, out_AWLEN;
  logic        in_P0_AWVALID, in_P1_AWVALID, out_P0_AWREADY, out_P1_AWREADY;
  logic [31:0] in_P0_WDATA, in_P1_WDATA, out_WDATA;
  logic [3:0]  in_P0_WSTRB, in_P1_WSTRB, out_WSTRB;
  logic        in_P0_WLAST, in_P1_WLAST, out_WLAST;
  logic        in_P0_WVALID, in_P1_WVALID, out_P0_WREADY, out_P1_WREADY;
  logic        out_AWVALID, in_AWREADY, out_WVALID, in_WREADY;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kernel3_gmem_c_m_axi_write_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAXREQS(4)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_P0_AWADDR(in_P0_AWADDR), .in_P0_AWLEN(in_P0_AWLEN), .in_P0_AWVALID(in_P0_AWVALID),
    .out_P0_AWREADY(out_P0_AWREADY),
    .in_P1_AWADDR(in_P1_AWADDR), .in_P1_AWLEN(in_P1_AWLEN), .in_P1_AWVALID(in_P1_AWVALID),
    .out_P1_AWREADY(out_P1_AWREADY),
    .in_P0_WDATA(in_P0_WDATA), .in_P0_WSTRB(in_P0_WSTRB), .in_P0_WLAST(in_P0_WLAST),
    .in_P0_WVALID(in_P0_WVALID), .out_P0_WREADY(out_P0_WREADY),
    .in_P1_WDATA(in_P1_WDATA), .in_P1_WSTRB(in_P1_WSTRB), .in_P1_WLAST(in_P1_WLAST),
    .in_P1_WVALID(in_P1_WVALID), .out_P1_WREADY(out_P1_WREADY),
    .out_AWADDR(out_AWADDR), .out_AWLEN(out_AWLEN), .out_AWVALID(out_AWVALID),
    .in_AWREADY(in_AWREADY),
    .out_WDATA(out_WDATA), .out_WSTRB(out_WSTRB), .out_WLAST(out_WLAST), .out_WVALID(out_WVALID),
    .in_WREADY(in_WREADY)
  );

  // Flag order: {AWVALID, P0_AWREADY, P1_AWREADY, WVALID, P0_WREADY, P1_WREADY}
  function automatic logic [5:0] flags();
    return {out_AWVALID, out_P0_AWREADY, out_P1_AWREADY, out_WVALID, out_P0_WREADY, out_P1_WREADY};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_f(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = flags();
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s flags observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_aw(input logic v0, input logic v1);
    in_P0_AWVALID = v0;
    in_P1_AWVALID = v1;
  endtask

  task automatic set_w(input logic v0, input logic l0, input logic v1, input logic l1);
    in_P0_WVALID = v0;
    in_P0_WLAST  = l0;
    in_P1_WVALID = v1;
    in_P1_WLAST  = l1;
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1;
    in_P0_AWADDR = 32'h0000_1000; in_P1_AWADDR = 32'h0000_2000;
    in_P0_AWLEN = 8'd0; in_P1_AWLEN = 8'd0;
    in_P0_WDATA = 32'hA0A0_0000; in_P1_WDATA = 32'hB0B0_0000;
    in_P0_WSTRB = 4'hF; in_P1_WSTRB = 4'h3;
    in_AWREADY = 1'b1; in_WREADY = 1'b1;
    set_aw(1, 1);
    set_w(1, 1, 1, 1);

    // Reset held with every input requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_f("reset_quiet", 6'b000000);
    end

    // Contention: alternate P0,P1,P0,P1 until the queue is full
    reset = 1'b0;
    set_w(0, 1, 0, 1);
    #1;
    chk_f("rr_c1", 6'b110000); chk("rr_c1_addr", out_AWADDR, 32'h0000_1000);
    tick();
    chk_f("rr_c2", 6'b101010); chk("rr_c2_addr", out_AWADDR, 32'h0000_2000);
    tick();
    chk_f("rr_c3", 6'b110010); chk("rr_c3_addr", out_AWADDR, 32'h0000_1000);
    tick();
    chk_f("rr_c4", 6'b101010); chk("rr_c4_addr", out_AWADDR, 32'h0000_2000);
    tick();
    set_aw(0, 0);
    set_w(1, 1, 1, 1);
    #1;
    chk_f("drain_0", 6'b000110); chk("drain_0_data", out_WDATA, 32'hA0A0_0000);
    tick();
    chk_f("drain_1", 6'b000101); chk("drain_1_data", out_WDATA, 32'hB0B0_0000);
    tick();
    chk_f("drain_2", 6'b000110); chk("drain_2_data", out_WDATA, 32'hA0A0_0000);
    tick();
    chk_f("drain_3", 6'b000101); chk("drain_3_data", out_WDATA, 32'hB0B0_0000);
    tick();
    chk_f("drain_empty", 6'b000000);
    set_w(0, 1, 0, 1);

    // Stall lock: P1 stalled, then P0 joins; address must stay P1's
    set_aw(0, 1);
    in_AWREADY = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_f("stall_p1", 6'b100000); chk("stall_p1_addr", out_AWADDR, 32'h0000_2000);
      tick();
    end
    set_aw(1, 1);
    #1;
    chk_f("stall_both", 6'b100000); chk("stall_both_addr", out_AWADDR, 32'h0000_2000);
    in_AWREADY = 1'b1;
    #1;
    chk_f("stall_release", 6'b101000); chk("stall_release_addr", out_AWADDR, 32'h0000_2000);
    tick();
    chk_f("after_stall_p0", 6'b110001); chk("after_stall_addr", out_AWADDR, 32'h0000_1000);
    tick();
    set_aw(0, 0);
    set_w(1, 1, 1, 1);
    #1;
    chk_f("lock_drain_p1", 6'b000101);
    tick();
    chk_f("lock_drain_p0", 6'b000110);
    tick();
    set_w(0, 1, 0, 1);

    // Burst integrity: P0 4 beats then P1 1 beat
    set_aw(1, 0);
    in_P0_AWLEN = 8'd3;
    set_w(1, 0, 0, 1);
    #1;
    chk_f("burst_aw_p0_wblocked", 6'b110000); chk("burst_awlen_p0", 32'(out_AWLEN), 32'd3);
    tick();
    set_aw(0, 1);
    set_w(0, 0, 0, 1);
    #1;
    chk_f("burst_aw_p1", 6'b101010); chk("burst_awlen_p1", 32'(out_AWLEN), 32'd0);
    tick();
    set_aw(0, 0);
    for (int i = 0; i < 4; i++) begin
      in_P0_WDATA = 32'hA0A0_0000 + 32'(i);
      set_w(1, (i == 3), 1, 1);
      #1;
      chk_f("burst_p0_beat", 6'b000110);
      chk("burst_p0_data", out_WDATA, 32'hA0A0_0000 + 32'(i));
      chk("burst_p0_last", 32'(out_WLAST), 32'((i == 3)));
      tick();
    end
    chk_f("burst_p1_beat", 6'b000101);
    chk("burst_p1_data", out_WDATA, 32'hB0B0_0000);
    chk("burst_p1_strb", 32'(out_WSTRB), 32'h3);
    tick();
    chk_f("burst_empty", 6'b000000);
    set_w(0, 1, 0, 1);
    in_P0_WDATA = 32'hA0A0_0000;
    in_P0_AWLEN = 8'd0;

    // Queue full with W held off
    set_aw(1, 0);
    #1;
    chk_f("full_aw0", 6'b110000);
    tick();
    for (int i = 1; i < 4; i++) begin
      chk_f("full_awn", 6'b110010);
      tick();
    end
    set_w(1, 1, 0, 1);
    #1;
    chk_f("full_blocked", 6'b000110);
    tick();
    set_w(0, 1, 0, 1);
    #1;
    chk_f("full_reopen", 6'b110010);
    tick();
    set_aw(0, 0);
    set_w(1, 1, 0, 1);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_f("full_drain", 6'b000110);
      tick();
    end
    chk_f("full_drained", 6'b000000);
    set_w(0, 1, 0, 1);

    // Reset after 2 of 4 beats, then a fresh P1 burst
    set_aw(1, 0);
    in_P0_AWLEN = 8'd3;
    #1;
    chk_f("mid_aw", 6'b110000);
    tick();
    set_aw(0, 0);
    set_w(1, 0, 0, 1);
    #1;
    chk_f("mid_beat0", 6'b000110);
    tick();
    chk_f("mid_beat1", 6'b000110);
    tick();
    reset = 1'b1;
    #1;
    chk_f("mid_in_reset", 6'b000000);
    tick();
    reset = 1'b0;
    #1;
    chk_f("mid_after_reset", 6'b000000);
    set_aw(0, 1);
    #1;
    chk_f("mid_p1_aw", 6'b101000); chk("mid_p1_addr", out_AWADDR, 32'h0000_2000);
    tick();
    set_aw(0, 0);
    set_w(1, 0, 1, 1);
    #1;
    chk_f("mid_p1_beat", 6'b000101); chk("mid_p1_data", out_WDATA, 32'hB0B0_0000);
    tick();
    chk_f("mid_done", 6'b000000);
    set_w(0, 1, 0, 1);

    // clk_en low freezes state; outputs still combinational
    clk_en = 1'b0;
    set_aw(1, 0);
    set_w(1, 1, 0, 1);
    #1;
    chk_f("clken_off_a", 6'b110000);
    tick();
    chk_f("clken_off_b", 6'b110000);
    clk_en = 1'b1;
    tick();
    set_aw(0, 0);
    #1;
    chk_f("clken_on", 6'b000110);
    tick();
    chk_f("clken_drained", 6'b000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
